// File: rtl/car_ampl_pkg.sv
// Shared definitions for the carrier amplitude stage: ramp state encoding,
// mid-scale/unity constant functions and a saturating clamp helper.
package car_ampl_pkg;

    // Ramp state encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ramp_state_e;

    // Offset-binary mid-scale code for a w-bit sample
    function automatic int unsigned MIDSCALE(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    // Unity gain code for a w-bit unsigned gain
    function automatic int unsigned UNITY(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    // Clamp v into [lo, hi]
    function automatic longint sat_range(input longint v, input longint lo, input longint hi);
        longint r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/car_ampl_ramp.sv
// Slew-limited gain ramp: accepts a target gain in IDLE and walks gain_cur
// toward it by STEP every RAMP_DIV clocks, landing exactly on the target.
module car_ampl_ramp
    import car_ampl_pkg::*;
#(
    parameter int unsigned GW       = 10,
    parameter int unsigned GAIN_RST = UNITY(GW),
    parameter int unsigned STEP     = 16,
    parameter int unsigned RAMP_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [GW-1:0] gain_req,
    input  logic          gain_req_valid,
    output logic          gain_req_ready,
    output logic          ramp_busy,
    output logic [GW-1:0] gain_cur
);

    localparam int unsigned CW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [0:0]  IDLE = ST_IDLE;
    localparam logic [0:0]  RAMP = ST_RAMP;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [GW-1:0] gain_tgt;
    logic [GW-1:0] gain_tgt_nxt;
    logic [GW-1:0] gain_cur_nxt;
    logic [GW-1:0] diff;
    logic [GW-1:0] stepped;

    // State, tick counter, gains and registered handshake/busy flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            gain_cur       <= GW'(GAIN_RST);
            gain_tgt       <= GW'(GAIN_RST);
            gain_req_ready <= 1'b1;
            ramp_busy      <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            gain_cur       <= gain_cur_nxt;
            gain_tgt       <= gain_tgt_nxt;
            gain_req_ready <= (state_nxt == IDLE);
            ramp_busy      <= (state_nxt == RAMP);
        end
    end

    // Next-state logic; the final step is clamped onto the target
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        gain_tgt_nxt = gain_tgt;
        gain_cur_nxt = gain_cur;
        diff         = '0;
        stepped      = gain_cur;

        if (gain_cur < gain_tgt) begin
            diff    = gain_tgt - gain_cur;
            stepped = (32'(diff) <= STEP) ? gain_tgt : gain_cur + GW'(STEP);
        end else begin
            diff    = gain_cur - gain_tgt;
            stepped = (32'(diff) <= STEP) ? gain_tgt : gain_cur - GW'(STEP);
        end

        case (state)
            IDLE: begin
                if (gain_req_valid) begin
                    gain_tgt_nxt = gain_req;
                    if (gain_req != gain_cur) begin
                        state_nxt = RAMP;
                        cnt_nxt   = '0;
                    end
                end
            end
            RAMP: begin
                if (cnt == CW'(RAMP_DIV - 1)) begin
                    cnt_nxt      = '0;
                    gain_cur_nxt = stepped;
                    if (stepped == gain_tgt) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/car_ampl_scaler.sv
// Carrier amplitude stage: scales offset-binary carrier samples by the
// ramped gain through a 3-stage pipeline and re-centres on mid-scale.
// Optional feature macro: CAR_AMPL_AM_EN adds the am_in port, whose signed
// value is added (saturated) to the gain per sample.
module car_ampl_scaler
    import car_ampl_pkg::*;
#(
    parameter int unsigned DW       = 12,
    parameter int unsigned GW       = 10,
    parameter int unsigned GAIN_RST = UNITY(GW),
    parameter int unsigned STEP     = 16,
    parameter int unsigned RAMP_DIV = 4
`ifdef CAR_AMPL_AM_EN
    ,
    parameter int unsigned AMW      = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         dac_car,
    input  logic                  dac_car_valid,
    input  logic [GW-1:0]         gain_req,
    input  logic                  gain_req_valid,
    output logic                  gain_req_ready,
`ifdef CAR_AMPL_AM_EN
    input  logic signed [AMW-1:0] am_in,
`endif
    output logic [DW-1:0]         dac_car_ampl,
    output logic                  dac_car_ampl_valid,
    output logic                  ramp_busy,
    output logic [GW-1:0]         gain_cur
);

    localparam int unsigned PW  = DW + GW + 1;
    localparam int unsigned MID = MIDSCALE(DW);

    logic signed [DW:0]   s_c;
    logic [GW-1:0]        geff_c;
    logic signed [PW-1:0] s_ext_c;
    logic signed [PW-1:0] g_ext_c;
    logic signed [PW-1:0] p_c;
    logic signed [PW:0]   q_c;
    logic [DW-1:0]        out_c;

    logic                 s1_v;
    logic signed [DW:0]   s1_s;
    logic [GW-1:0]        s1_g;
    logic                 s2_v;
    logic signed [PW-1:0] s2_p;

    car_ampl_ramp #(
        .GW       (GW),
        .GAIN_RST (GAIN_RST),
        .STEP     (STEP),
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp (
        .clk            (clk),
        .rst            (rst),
        .gain_req       (gain_req),
        .gain_req_valid (gain_req_valid),
        .gain_req_ready (gain_req_ready),
        .ramp_busy      (ramp_busy),
        .gain_cur       (gain_cur)
    );

    // S1 operands: signed sample about mid-scale and effective gain
    assign s_c = $signed({1'b0, dac_car}) - $signed((DW + 1)'(MID));

`ifdef CAR_AMPL_AM_EN
    localparam int unsigned SW = ((GW > AMW) ? GW : AMW) + 2;
    logic signed [SW-1:0] gsum_c;

    // Gain plus AM offset, clamped to the unsigned gain range
    assign gsum_c = $signed(SW'({1'b0, gain_cur})) + SW'(am_in);
    assign geff_c = GW'(sat_range(longint'(gsum_c), 64'sd0, (64'sd1 <<< GW) - 64'sd1));
`else
    assign geff_c = gain_cur;
`endif

    // S2 product with operands sign/zero-extended to full product width
    assign s_ext_c = PW'(s1_s);
    assign g_ext_c = $signed(PW'({1'b0, s1_g}));
    assign p_c     = s_ext_c * g_ext_c;

    // S3: drop unity scaling (floor), re-centre and clamp to the DAC code range
    assign q_c   = (PW + 1)'(s2_p >>> (GW - 1)) + $signed((PW + 1)'(MID));
    assign out_c = DW'(sat_range(longint'(q_c), 64'sd0, (64'sd1 <<< DW) - 64'sd1));

    // Pipeline registers; output code holds while no valid sample emerges
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v               <= 1'b0;
            s1_s               <= '0;
            s1_g               <= '0;
            s2_v               <= 1'b0;
            s2_p               <= '0;
            dac_car_ampl_valid <= 1'b0;
            dac_car_ampl       <= DW'(MID);
        end else begin
            s1_v               <= dac_car_valid;
            s1_s               <= s_c;
            s1_g               <= geff_c;
            s2_v               <= s1_v;
            s2_p               <= p_c;
            dac_car_ampl_valid <= s2_v;
            if (s2_v) begin
                dac_car_ampl <= out_c;
            end
        end
    end

endmodule

// File: tb/tb_car_ampl_scaler.sv
// Self-checking bench for car_ampl_scaler (DW=12, GW=10, STEP=16, RAMP_DIV=4).
// Reference model: gain as a closed-form function of clocks since request
// acceptance, and sample scaling as plain integer arithmetic.
module tb_car_ampl_scaler;

    localparam int DW       = 12;
    localparam int GW       = 10;
    localparam int STEP     = 16;
    localparam int RAMP_DIV = 4;
    localparam int GAIN_RST = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] dac_car = '0;
    logic          dac_car_valid = 1'b0;
    logic [GW-1:0] gain_req = '0;
    logic          gain_req_valid = 1'b0;
    logic          gain_req_ready;
    logic [DW-1:0] dac_car_ampl;
    logic          dac_car_ampl_valid;
    logic          ramp_busy;
    logic [GW-1:0] gain_cur;
`ifdef CAR_AMPL_AM_EN
    logic signed [7:0] am_in = '0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int m_start = GAIN_RST;
    int m_tgt   = GAIN_RST;
    int m_since = 0;
    int m_gain  = GAIN_RST;
    bit m_busy  = 1'b0;
    bit pv[2];
    int pd[2];
    bit exp_v   = 1'b0;
    int exp_hold = 2048;
    bit last_acc = 1'b0;
    int busy_cnt;
    bit got;

    car_ampl_scaler #(
        .DW(DW), .GW(GW), .GAIN_RST(GAIN_RST), .STEP(STEP), .RAMP_DIV(RAMP_DIV)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dac_car            (dac_car),
        .dac_car_valid      (dac_car_valid),
        .gain_req           (gain_req),
        .gain_req_valid     (gain_req_valid),
        .gain_req_ready     (gain_req_ready),
`ifdef CAR_AMPL_AM_EN
        .am_in              (am_in),
`endif
        .dac_car_ampl       (dac_car_ampl),
        .dac_car_ampl_valid (dac_car_ampl_valid),
        .ramp_busy          (ramp_busy),
        .gain_cur           (gain_cur)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // floor((x - 2048) * g / 512) + 2048, clamped to the 12-bit code range
    function automatic int exp_scale(input int x, input int g);
        int p;
        int q;
        p = (x - 2048) * g;
        if (p >= 0) q = p / 512;
        else        q = -((-p + 511) / 512);
        q = q + 2048;
        if (q < 0)    q = 0;
        if (q > 4095) q = 4095;
        return q;
    endfunction

    // gain and busy as a function of clocks elapsed since acceptance
    function automatic void model_gain();
        int d, ad, mv, nsteps;
        d  = m_tgt - m_start;
        ad = (d < 0) ? -d : d;
        mv = STEP * (m_since / RAMP_DIV);
        if (mv > ad) mv = ad;
        m_gain = m_start + ((d < 0) ? -mv : mv);
        nsteps = (ad + STEP - 1) / STEP;
        m_busy = (m_since < nsteps * RAMP_DIV);
    endfunction

    // one clock: evaluate model on the edge, then compare all outputs
    task automatic step();
        bit r, acc, nv;
        int nd, rq, ge;
        r   = rst;
        acc = !rst && gain_req_valid && !m_busy;
        rq  = int'(gain_req);
        ge  = m_gain;
`ifdef CAR_AMPL_AM_EN
        ge = m_gain + int'(am_in);
        if (ge < 0)    ge = 0;
        if (ge > 1023) ge = 1023;
`endif
        nv  = dac_car_valid;
        nd  = exp_scale(int'(dac_car), ge);
        @(posedge clk);
        #1;
        if (r) begin
            m_start  = GAIN_RST;
            m_tgt    = GAIN_RST;
            m_since  = 0;
            pv[0]    = 1'b0;
            pv[1]    = 1'b0;
            exp_v    = 1'b0;
            exp_hold = 2048;
        end else begin
            if (acc) begin
                m_start = m_gain;
                m_tgt   = rq;
                m_since = 0;
            end else begin
                m_since++;
            end
            exp_v = pv[0];
            if (exp_v) exp_hold = pd[0];
            pv[0] = pv[1];
            pd[0] = pd[1];
            pv[1] = nv;
            pd[1] = nd;
        end
        last_acc = acc;
        model_gain();
        check("out_valid", 32'(dac_car_ampl_valid), 32'(exp_v));
        check("out_data",  32'(dac_car_ampl),       32'(exp_hold));
        check("gain_cur",  32'(gain_cur),           32'(m_gain));
        check("ramp_busy", 32'(ramp_busy),          32'(m_busy));
        check("req_ready", 32'(gain_req_ready),     32'(!m_busy));
    endtask

    task automatic rand_sample();
        dac_car_valid = ($urandom_range(3) != 0);
        dac_car       = 12'($urandom_range(4095));
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 1000 && m_busy; i++) begin
            rand_sample();
            step();
        end
        check("ramp_done", 32'(ramp_busy), 32'd0);
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = 0; pd[1] = 0;

        // reset state
        repeat (3) step();
        rst = 1'b0;

        // unity pass-through, single sample then random samples
        dac_car = 12'd3071; dac_car_valid = 1'b1;
        step();
        dac_car_valid = 1'b0;
        repeat (4) step();
        repeat (20) begin rand_sample(); step(); end

        // zero gain: 512 -> 0 ramp, busy for 128 clocks
        dac_car_valid = 1'b0;
        gain_req = 10'd0; gain_req_valid = 1'b1;
        step();
        gain_req_valid = 1'b0;
        busy_cnt = int'(ramp_busy);
        repeat (199) begin
            rand_sample();
            step();
            busy_cnt += int'(ramp_busy);
        end
        check("zero_ramp_len", 32'(busy_cnt), 32'd128);
        dac_car = 12'd4095; dac_car_valid = 1'b1; step();
        dac_car = 12'd0; step();
        dac_car_valid = 1'b0; repeat (4) step();

        // saturation at gain 1023
        gain_req = 10'd1023; gain_req_valid = 1'b1;
        step();
        gain_req_valid = 1'b0;
        run_until_idle();
        dac_car = 12'd4095; dac_car_valid = 1'b1; step();
        dac_car = 12'd0; step();
        dac_car_valid = 1'b0; repeat (4) step();
        repeat (20) begin rand_sample(); step(); end

        // handshake: request held through a ramp is taken once ready returns
        gain_req = 10'd600; gain_req_valid = 1'b1;
        step();
        gain_req = 10'd300;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            rand_sample();
            step();
            got = last_acc;
        end
        gain_req_valid = 1'b0;
        check("held_req_taken", 32'(got), 32'd1);
        run_until_idle();
        check("held_req_gain", 32'(gain_cur), 32'd300);

        // request equal to current gain: no ramp
        gain_req = 10'd300; gain_req_valid = 1'b1;
        step();
        gain_req_valid = 1'b0;
        repeat (6) begin rand_sample(); step(); end

        // mid-ramp reset
        rst = 1'b1; step(); rst = 1'b0; step();
        gain_req = 10'd0; gain_req_valid = 1'b1;
        step();
        gain_req_valid = 1'b0;
        repeat (40) begin rand_sample(); step(); end
        dac_car_valid = 1'b1;
        rst = 1'b1;
        step();
        check("rst_gain", 32'(gain_cur), 32'd512);
        check("rst_data", 32'(dac_car_ampl), 32'd2048);
        rst = 1'b0;
        dac_car_valid = 1'b0;
        repeat (4) step();

`ifdef CAR_AMPL_AM_EN
        // AM: gain 512 with am_in = -128 -> g_eff 384
        am_in = -8'sd128; dac_car = 12'd3071; dac_car_valid = 1'b1;
        step();
        dac_car_valid = 1'b0; am_in = '0;
        repeat (3) step();
        check("am_neg", 32'(dac_car_ampl), 32'd2815);
`endif

        // randomized traffic with occasional requests and resets
        repeat (1500) begin
            rand_sample();
`ifdef CAR_AMPL_AM_EN
            am_in = 8'($urandom_range(255));
`endif
            gain_req_valid = ($urandom_range(19) == 0);
            gain_req       = 10'($urandom_range(1023));
            rst            = ($urandom_range(399) == 0);
            step();
        end
        rst = 1'b0;
        gain_req_valid = 1'b0;
        dac_car_valid = 1'b0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/car_ampl_scaler.md
# car_ampl_scaler

Parametrised carrier amplitude stage that sits between the carrier NCO/DDS output and the DAC driver, replacing the fixed pass-through register stage. Scales each offset-binary carrier sample by a programmable gain and re-centres it on mid-scale. Gain changes are slew-limited by a ramp state machine to avoid spectral splatter. An optional AM input modulates the gain per sample.

## Interface
Parameters:
- DW, 12: carrier sample width, offset-binary, mid-scale = 2^(DW-1).
- GW, 10: gain width, unsigned; unity gain = 2^(GW-1).
- GAIN_RST, 2^(GW-1): gain loaded at reset.
- STEP, 16: gain increment per ramp tick.
- RAMP_DIV, 4: clocks per ramp tick, ≥1.
- AMW, 8: AM input width, signed. Used only with CAR_AMPL_AM_EN.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- dac_car  in  DW  carrier sample, offset-binary.
- dac_car_valid  in  1  sample strobe.
- gain_req  in  GW  requested target gain.
- gain_req_valid  in  1  request strobe.
- gain_req_ready  out  1  request accepted when valid && ready.
- am_in  in  AMW  signed AM offset added to gain. Present only with CAR_AMPL_AM_EN.
- dac_car_ampl  out  DW  scaled sample, offset-binary.
- dac_car_ampl_valid  out  1  output strobe.
- ramp_busy  out  1  ramp in progress.
- gain_cur  out  GW  current applied ramp gain.

## Operation
- Ramp FSM, states IDLE and RAMP; reset state is IDLE.
- gain_req_ready = (state == IDLE).
- IDLE: on gain_req_valid, latch gain_tgt = gain_req.
  - If gain_tgt != gain_cur, go to RAMP and clear the tick counter.
  - If they are equal, stay in IDLE.
- RAMP:
  - The tick counter counts 0..RAMP_DIV-1. On the terminal count, gain_cur moves toward gain_tgt by STEP.
  - The last step is clamped so gain_cur lands exactly on gain_tgt.
  - When gain_cur == gain_tgt after the update, return to IDLE.
  - Requests are not accepted in RAMP (ready = 0).
- ramp_busy = (state == RAMP).
- Datapath, a 3-stage pipeline that advances every clock; valid travels alongside the data:
  - S1: s = dac_car − 2^(DW-1), signed DW+1 bits. g_eff = gain_cur, or with AM enabled, g_eff = saturate(gain_cur + sign-extended am_in) to [0, 2^GW−1]. Both are registered.
  - S2: p = s × g_eff, signed DW+GW+1 bits, registered.
  - S3: q = (p >>> (GW−1)) + 2^(DW-1), arithmetic shift (floor). Saturate q to [0, 2^DW−1] and register it into dac_car_ampl.
- Output hold: when dac_car_ampl_valid is 0, dac_car_ampl holds its last value.
- Gain capture: the gain used for a sample is the one sampled in S1 during that sample's input cycle. A ramp update in the same cycle is not visible until the next sample.

## Timing
- Latency: dac_car_valid at cycle n produces dac_car_ampl_valid and data at cycle n+3.
- Throughput: one sample per clock.
- Reset values:
  - dac_car_ampl = 2^(DW-1) (silence).
  - dac_car_ampl_valid = 0; all pipeline valids = 0.
  - gain_cur = GAIN_RST; gain_tgt = GAIN_RST.
  - ramp_busy = 0; gain_req_ready = 1 from the first cycle after rst deasserts.
- Reset mid-ramp: the ramp aborts and gain_cur returns to GAIN_RST. In-flight samples are dropped and produce no output valid.
- Handshake: a request is taken only on the cycle where valid && ready. A request that is held while ready = 0 is taken on the first cycle ready is 1.
- Ramp duration: ceil(|gain_tgt − gain_cur| / STEP) × RAMP_DIV cycles. ramp_busy rises the cycle after acceptance.
- A request arriving on the same cycle the ramp finishes is not accepted; ready rises the following cycle.

## Configuration
- CAR_AMPL_AM_EN defined:
  - am_in port exists.
  - g_eff = saturated gain_cur + am_in, with am_in sampled in S1 with the sample.
- CAR_AMPL_AM_EN undefined:
  - am_in port is absent; g_eff = gain_cur.
  - Latency is unchanged at 3.

## Structure
- Shared package car_ampl_pkg holds:
  - the ramp state enum (IDLE, RAMP);
  - the MIDSCALE(DW) and UNITY(GW) constant functions;
  - the saturate helper.
- Sub-module car_ampl_ramp holds the FSM, the tick counter and gain_cur/gain_tgt.
- The top level instantiates car_ampl_ramp and implements the 3-stage datapath.

## Test plan
All cases use DW=12, GW=10, STEP=16, RAMP_DIV=4.
- Unity pass-through: GAIN_RST=512, dac_car=3071 → dac_car_ampl=3071 at n+3, valid for 1 cycle.
- Positive saturation: ramp to gain 1023, dac_car=4095 → 4095. Same gain, dac_car=0 → 0 (negative clamp).
- Zero gain: request 0 from 512 → ramp_busy high for 128 cycles, gain_cur steps 512→496→…→0. Afterwards any dac_car → 2048.
- Handshake: gain_req_valid held high during a ramp with gain_req=300 → not taken until ready=1, then accepted. A request equal to gain_cur → no RAMP entry, ramp_busy stays 0.
- Mid-ramp reset: assert rst during a 512→0 ramp → gain_cur=512, dac_car_ampl=2048, valid=0 the next cycle, ready=1 after release.
- AM (CAR_AMPL_AM_EN): gain 512, am_in=−128, dac_car=3071 → (1023×384)>>9 = 767 → 2815. am_in=+127 at gain 1000 → g_eff clamps to 1023.
